// File: rtl/nco_dac_spi_tx_if.sv
// -----------------------------------------------------------------------------
// nco_dac_spi_tx_if
// Purpose : bundles the sample handshake and the DAC-side SPI pins of
//           nco_dac_spi_tx so the block and its neighbours connect with a
//           single port.
// Signals : sample_in[7:0]  waveform sample from the NCO
//           sample_valid    sample_in is valid this cycle
//           sample_ready    serializer can accept a sample this cycle
//           dac_sclk        SPI clock (idles low, mode 0)
//           dac_cs_n        DAC chip select, active low
//           dac_mosi        SPI data, MSB first
//           busy            serializer is not idle
//           frame_done      one-cycle pulse on the last cycle of a frame
// Modports: master - the NCO / observer side
//           slave  - the serializer (nco_dac_spi_tx)
// -----------------------------------------------------------------------------
interface nco_dac_spi_tx_if;
  logic [7:0] sample_in;
  logic       sample_valid;
  logic       sample_ready;
  logic       dac_sclk;
  logic       dac_cs_n;
  logic       dac_mosi;
  logic       busy;
  logic       frame_done;

  modport master (
    output sample_in, sample_valid,
    input  sample_ready, dac_sclk, dac_cs_n, dac_mosi, busy, frame_done
  );

  modport slave (
    input  sample_in, sample_valid,
    output sample_ready, dac_sclk, dac_cs_n, dac_mosi, busy, frame_done
  );
endinterface

// File: rtl/nco_dac_spi_tx.sv
// -----------------------------------------------------------------------------
// nco_dac_spi_tx
// Purpose : serialises each 8-bit NCO sample into a 16-bit SPI write frame
//           {CMD_BITS, sample, 4'b0000}, MSB first, SPI mode 0. Samples enter
//           through a valid/ready handshake so the NCO is throttled to the
//           SPI frame rate.
// Ports   : clk_50MHz  system clock
//           reset      asynchronous, active-high reset
//           bus        nco_dac_spi_tx_if.slave (handshake + SPI pins + status)
// Params  : CLK_DIV         system clocks per SCLK half-period (1..255)
//           CMD_BITS        command nibble, frame bits [15:12]
//           CS_HIGH_CYCLES  cycles cs_n is held high after a frame (1..255)
// Option  : DAC_SPI_DOUBLE_BUFFER_EN - when defined, a one-entry pending
//           register lets the next sample be accepted while a frame is in
//           flight, and frames run back to back (no IDLE cycle between them).
// All outputs are registered: the output process computes their next values
// from the next-state values so they line up with the state they belong to.
// -----------------------------------------------------------------------------
module nco_dac_spi_tx #(
  parameter int         CLK_DIV        = 2,
  parameter logic [3:0] CMD_BITS       = 4'b0011,
  parameter int         CS_HIGH_CYCLES = 2
) (
  input  logic            clk_50MHz,
  input  logic            reset,
  nco_dac_spi_tx_if.slave bus
);

  localparam logic [7:0] DIV_RELOAD  = 8'(CLK_DIV - 1);
  localparam logic [7:0] HOLD_RELOAD = 8'(CS_HIGH_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_SHIFT = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t      r_state, w_state_next;
  logic [7:0]  r_div, w_div_next;             // phase divider, reloads each phase
  logic [3:0]  r_bit_cnt, w_bit_cnt_next;     // index of bit being sent (0..15)
  logic        r_sclk_phase, w_sclk_phase_next; // 1 = sclk-high phase of SHIFT
  logic [7:0]  r_hold_cnt, w_hold_cnt_next;
  logic [15:0] r_frame, w_frame_next;         // shift register, [15] is on mosi

  logic r_sample_ready, w_sample_ready_next;
  logic r_sclk, w_sclk_next;
  logic r_cs_n, w_cs_n_next;
  logic r_mosi, w_mosi_next;
  logic r_busy, w_busy_next;
  logic r_frame_done, w_frame_done_next;

  logic w_accept;
  logic w_last_hold;

`ifdef DAC_SPI_DOUBLE_BUFFER_EN
  logic       r_pend_full, w_pend_full_next;
  logic [7:0] r_pend_data, w_pend_data_next;
`endif

  assign w_accept    = bus.sample_valid && r_sample_ready;
  assign w_last_hold = (r_state == S_HOLD) && (r_hold_cnt == 8'd0);

  // ---------------------------------------------------------------------------
  // State register (also holds counters, frame and the registered outputs)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_div          <= 8'd0;
      r_bit_cnt      <= 4'd0;
      r_sclk_phase   <= 1'b0;
      r_hold_cnt     <= 8'd0;
      r_frame        <= 16'd0;
      r_sample_ready <= 1'b1;
      r_sclk         <= 1'b0;
      r_cs_n         <= 1'b1;
      r_mosi         <= 1'b0;
      r_busy         <= 1'b0;
      r_frame_done   <= 1'b0;
`ifdef DAC_SPI_DOUBLE_BUFFER_EN
      r_pend_full    <= 1'b0;
      r_pend_data    <= 8'd0;
`endif
    end else begin
      r_state        <= w_state_next;
      r_div          <= w_div_next;
      r_bit_cnt      <= w_bit_cnt_next;
      r_sclk_phase   <= w_sclk_phase_next;
      r_hold_cnt     <= w_hold_cnt_next;
      r_frame        <= w_frame_next;
      r_sample_ready <= w_sample_ready_next;
      r_sclk         <= w_sclk_next;
      r_cs_n         <= w_cs_n_next;
      r_mosi         <= w_mosi_next;
      r_busy         <= w_busy_next;
      r_frame_done   <= w_frame_done_next;
`ifdef DAC_SPI_DOUBLE_BUFFER_EN
      r_pend_full    <= w_pend_full_next;
      r_pend_data    <= w_pend_data_next;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next      = r_state;
    w_div_next        = r_div;
    w_bit_cnt_next    = r_bit_cnt;
    w_sclk_phase_next = r_sclk_phase;
    w_hold_cnt_next   = r_hold_cnt;
    w_frame_next      = r_frame;
`ifdef DAC_SPI_DOUBLE_BUFFER_EN
    w_pend_full_next  = r_pend_full;
    w_pend_data_next  = r_pend_data;
`endif

    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = S_SETUP;
          w_frame_next = {CMD_BITS, bus.sample_in, 4'b0000};
          w_div_next   = DIV_RELOAD;
        end
      end

      S_SETUP: begin
        if (r_div == 8'd0) begin
          w_state_next      = S_SHIFT;
          w_div_next        = DIV_RELOAD;
          w_sclk_phase_next = 1'b1;
          w_bit_cnt_next    = 4'd0;
        end else begin
          w_div_next = r_div - 8'd1;
        end
      end

      S_SHIFT: begin
        if (r_div != 8'd0) begin
          w_div_next = r_div - 8'd1;
        end else begin
          w_div_next = DIV_RELOAD;
          if (r_sclk_phase) begin
            // High-to-low edge: present the next bit. After the 16th bit the
            // zero fill leaves mosi low for the final low phase.
            w_sclk_phase_next = 1'b0;
            w_frame_next      = {r_frame[14:0], 1'b0};
          end else if (r_bit_cnt == 4'd15) begin
            w_state_next    = S_HOLD;
            w_hold_cnt_next = HOLD_RELOAD;
          end else begin
            w_bit_cnt_next    = r_bit_cnt + 4'd1;
            w_sclk_phase_next = 1'b1;
          end
        end
      end

      S_HOLD: begin
        if (r_hold_cnt != 8'd0) begin
          w_hold_cnt_next = r_hold_cnt - 8'd1;
        end else begin
          w_state_next = S_IDLE;
`ifdef DAC_SPI_DOUBLE_BUFFER_EN
          // Chain straight into the next frame. A sample arriving on this very
          // cycle (pending empty, so ready is high) is loaded directly rather
          // than parked, so IDLE never has to look at the pending register.
          if (r_pend_full) begin
            w_state_next     = S_SETUP;
            w_frame_next     = {CMD_BITS, r_pend_data, 4'b0000};
            w_div_next       = DIV_RELOAD;
            w_pend_full_next = 1'b0;
          end else if (w_accept) begin
            w_state_next = S_SETUP;
            w_frame_next = {CMD_BITS, bus.sample_in, 4'b0000};
            w_div_next   = DIV_RELOAD;
          end
`endif
        end
      end

      default: w_state_next = S_IDLE;
    endcase

`ifdef DAC_SPI_DOUBLE_BUFFER_EN
    // Mid-frame acceptance parks the sample until the current frame ends.
    if (w_accept && (r_state != S_IDLE) && !w_last_hold) begin
      w_pend_full_next = 1'b1;
      w_pend_data_next = bus.sample_in;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Output logic (next values of the registered outputs)
  // ---------------------------------------------------------------------------
  always_comb begin
    w_cs_n_next       = 1'b1;
    w_sclk_next       = 1'b0;
    w_mosi_next       = 1'b0;
    w_busy_next       = (w_state_next != S_IDLE);
    w_frame_done_next = (w_state_next == S_HOLD) && (w_hold_cnt_next == 8'd0);

    if ((w_state_next == S_SETUP) || (w_state_next == S_SHIFT)) begin
      w_cs_n_next = 1'b0;
      w_mosi_next = w_frame_next[15];
      w_sclk_next = (w_state_next == S_SHIFT) && w_sclk_phase_next;
    end

`ifdef DAC_SPI_DOUBLE_BUFFER_EN
    w_sample_ready_next = !w_pend_full_next;
`else
    w_sample_ready_next = (w_state_next == S_IDLE);
`endif
  end

  assign bus.sample_ready = r_sample_ready;
  assign bus.dac_sclk     = r_sclk;
  assign bus.dac_cs_n     = r_cs_n;
  assign bus.dac_mosi     = r_mosi;
  assign bus.busy         = r_busy;
  assign bus.frame_done   = r_frame_done;

endmodule

// File: tb/tb_nco_dac_spi_tx.sv
// -----------------------------------------------------------------------------
// tb_nco_dac_spi_tx
// Two serializers run side by side: dut 0 at CLK_DIV=2, dut 1 at CLK_DIV=1.
// A frame-level reference model predicts every output each cycle from the
// frame start cycle and the frame word using plain arithmetic; an SPI
// monitor rebuilds the 16-bit words seen on the wire at sclk rising edges.
// -----------------------------------------------------------------------------
module tb_nco_dac_spi_tx;

  localparam int         CSH = 2;
  localparam logic [3:0] CMD = 4'b0011;
`ifdef DAC_SPI_DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nco_dac_spi_tx_if if_a ();
  nco_dac_spi_tx_if if_b ();

  nco_dac_spi_tx #(.CLK_DIV(2), .CMD_BITS(CMD), .CS_HIGH_CYCLES(CSH)) u_dut_a (
    .clk_50MHz (clk),
    .reset     (rst),
    .bus       (if_a)
  );

  nco_dac_spi_tx #(.CLK_DIV(1), .CMD_BITS(CMD), .CS_HIGH_CYCLES(CSH)) u_dut_b (
    .clk_50MHz (clk),
    .reset     (rst),
    .bus       (if_b)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  int    cd  [2] = '{2, 1};
  int    per [2];                 // busy cycles per frame: 33*CLK_DIV + CSH
  string names [6] = '{"sample_ready", "dac_sclk", "dac_cs_n", "dac_mosi", "busy", "frame_done"};

  // reference model
  bit          m_act  [2];
  int          m_s    [2];
  logic [15:0] m_w    [2];
  bit          m_pend [2];
  logic [15:0] m_pw   [2];
  int          frames_started [2];

  // stimulus
  logic [7:0] q [2][$];
  bit         v [2];
  logic [7:0] x [2];
  int         gap [2];
  bit         acc_flag [2];
  bit         rand_gap;

  // SPI monitor
  logic        prev_sclk [2];
  logic        prev_cs   [2];
  logic [15:0] cap       [2];
  logic [15:0] last_cap  [2];
  int          nbits     [2];
  int          cs_low    [2];
  int          fall_cyc  [2];
  int          last_period [2];
  int          done_cyc  [2];
  int          frames_seen [2];

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s dut%0d cyc=%0d observed=%0h expected=%0h", tag, d, cyc, obs, exp);
    end
  endtask

  function automatic logic [15:0] word_of(input logic [7:0] s);
    return {CMD, s, 4'b0000};
  endfunction

  function automatic bit m_ready(input int d);
    if (DB) return !m_pend[d];
    return !m_act[d];
  endfunction

  // expected {ready, sclk, cs_n, mosi, busy, frame_done} for the current cycle
  function automatic logic [5:0] m_out(input int d);
    int t, c, h, k;
    logic [5:0] o;
    c = cd[d];
    o = {m_ready(d), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    if (m_act[d]) begin
      t    = cyc - m_s[d];
      o[1] = 1'b1;
      o[0] = (t == per[d] - 1);
      if (t < 33 * c) begin
        o[3] = 1'b0;
        if (t < c) begin
          o[2] = m_w[d][15];
        end else begin
          h    = (t - c) / c;          // half-period index within the shift
          o[4] = (h % 2 == 0);
          k    = (h + 1) / 2;          // bits already shifted out
          o[2] = (k <= 15) ? m_w[d][15 - k] : 1'b0;
        end
      end
    end
    return o;
  endfunction

  function automatic logic [5:0] dut_out(input int d);
    if (d == 0)
      return {if_a.sample_ready, if_a.dac_sclk, if_a.dac_cs_n, if_a.dac_mosi, if_a.busy, if_a.frame_done};
    return {if_b.sample_ready, if_b.dac_sclk, if_b.dac_cs_n, if_b.dac_mosi, if_b.busy, if_b.frame_done};
  endfunction

  task automatic start_frame(input int d, input logic [15:0] w);
    m_act[d] = 1'b1;
    m_s[d]   = cyc + 1;
    m_w[d]   = w;
    frames_started[d]++;
  endtask

  // advance the model across one rising edge (cyc is still the old cycle)
  task automatic model_edge(input int d);
    bit acc;
    int t;
    acc = v[d] && m_ready(d);
    t   = cyc - m_s[d];
    if (acc) acc_flag[d] = 1'b1;
    if (m_act[d] && (t != per[d] - 1)) begin
      if (acc) begin
        m_pend[d] = 1'b1;
        m_pw[d]   = word_of(x[d]);
      end
    end else if (m_act[d]) begin
      m_act[d] = 1'b0;
      if (m_pend[d]) begin
        start_frame(d, m_pw[d]);
        m_pend[d] = 1'b0;
      end else if (acc) begin
        start_frame(d, word_of(x[d]));
      end
    end else if (acc) begin
      start_frame(d, word_of(x[d]));
    end
  endtask

  task automatic clear(input int d);
    if (m_act[d]) frames_started[d]--;
    m_act[d]     = 1'b0;
    m_pend[d]    = 1'b0;
    acc_flag[d]  = 1'b0;
    prev_sclk[d] = 1'b0;
    prev_cs[d]   = 1'b1;
    cap[d]       = 16'd0;
    nbits[d]     = 0;
    cs_low[d]    = 0;
    fall_cyc[d]  = -1;
  endtask

  task automatic monitor(input int d, input logic [5:0] o);
    logic sclk, cs, mosi;
    sclk = o[4]; cs = o[3]; mosi = o[2];
    if (sclk && !prev_sclk[d]) begin
      cap[d] = {cap[d][14:0], mosi};
      nbits[d]++;
    end
    if (!cs) cs_low[d]++;
    if (!cs && prev_cs[d]) begin
      if (fall_cyc[d] >= 0) last_period[d] = cyc - fall_cyc[d];
      fall_cyc[d] = cyc;
    end
    if (cs && !prev_cs[d]) begin
      chk("wire_word", d, cap[d], m_w[d]);
      chk("rise_count", d, nbits[d], 16);
      chk("cs_low_cycles", d, cs_low[d], 33 * cd[d]);
      last_cap[d] = cap[d];
      frames_seen[d]++;
      cap[d] = 16'd0; nbits[d] = 0; cs_low[d] = 0;
    end
    if (o[0]) done_cyc[d] = cyc;
    prev_sclk[d] = sclk;
    prev_cs[d]   = cs;
  endtask

  task automatic feed(input int d);
    if (acc_flag[d]) begin
      q[d].delete(0);
      acc_flag[d] = 1'b0;
      gap[d] = rand_gap ? int'($urandom_range(0, 4)) : 0;
    end
    if (gap[d] > 0) begin
      gap[d]--;
      v[d] = 1'b0; x[d] = 8'($urandom);
    end else if (q[d].size() > 0) begin
      v[d] = 1'b1; x[d] = q[d][0];
    end else begin
      v[d] = 1'b0; x[d] = 8'($urandom);
    end
  endtask

  task automatic drive();
    if_a.sample_valid = v[0]; if_a.sample_in = x[0];
    if_b.sample_valid = v[1]; if_b.sample_in = x[1];
  endtask

  task automatic step();
    logic [5:0] o, e;
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst) clear(d);
      else     model_edge(d);
    end
    cyc++;
    #1;
    for (int d = 0; d < 2; d++) begin
      o = dut_out(d);
      e = m_out(d);
      for (int i = 0; i < 6; i++) chk(names[i], d, o[5 - i], e[5 - i]);
      if (!rst) monitor(d, o);
      feed(d);
    end
    drive();
  endtask

  task automatic run_until_idle(input int max_cyc);
    bit idle;
    idle = 1'b0;
    for (int n = 0; n < max_cyc; n++) begin
      if (q[0].size() == 0 && q[1].size() == 0 && !v[0] && !v[1] &&
          !m_act[0] && !m_act[1] && !m_pend[0] && !m_pend[1]) begin
        idle = 1'b1;
        break;
      end
      step();
    end
    chk("idle_timeout", 0, idle, 1);
  endtask

  initial begin
    bit found;
    for (int d = 0; d < 2; d++) begin
      per[d] = 33 * cd[d] + CSH;
      frames_started[d] = 0; frames_seen[d] = 0;
      v[d] = 1'b0; x[d] = 8'd0; gap[d] = 0;
      m_s[d] = 0; m_w[d] = 16'd0; m_pw[d] = 16'd0;
      last_cap[d] = 16'd0; last_period[d] = 0; done_cyc[d] = 0;
      clear(d);
    end
    rand_gap = 1'b0;
    drive();

    // reset values, then idle with no valid
    repeat (3) step();
    rst = 1'b0;
    repeat (20) step();

    // single samples: A5 on CLK_DIV=2, FF on CLK_DIV=1
    q[0].push_back(8'hA5);
    q[1].push_back(8'hFF);
    run_until_idle(200);
    chk("a5_word", 0, last_cap[0], 16'h3A50);
    chk("ff_word", 1, last_cap[1], 16'h3FF0);
    chk("done_after_cs_fall", 0, done_cyc[0] - fall_cyc[0], 67);
    chk("done_after_cs_fall", 1, done_cyc[1] - fall_cyc[1], 34);
    repeat (4) step();

    // valid held high across three samples
    foreach (cd[d]) begin
      q[d].push_back(8'h00); q[d].push_back(8'h80); q[d].push_back(8'hFF);
    end
    run_until_idle(400);
    chk("frame_period", 0, last_period[0], DB ? 68 : 69);
    chk("frame_period", 1, last_period[1], DB ? 35 : 36);
    chk("last_of_three", 0, last_cap[0], 16'h3FF0);

    // random samples with random valid gaps
    rand_gap = 1'b1;
    for (int i = 0; i < 8; i++) begin
      q[0].push_back(8'($urandom));
      q[1].push_back(8'($urandom));
    end
    run_until_idle(3000);
    rand_gap = 1'b0;
    repeat (3) step();

    // reset while frame bit 7 is on the wire, then a clean frame
    q[0].push_back(8'hC3);
    found = 1'b0;
    for (int n = 0; n < 200; n++) begin
      step();
      if (m_act[0] && (cyc - m_s[0] == 34)) begin
        found = 1'b1;
        break;
      end
    end
    chk("reach_bit7", 0, found, 1);
    chk("bit7_sclk_before_reset", 0, if_a.dac_sclk, 1);
    rst = 1'b1;
    #1;
    chk("async_cs_n", 0, if_a.dac_cs_n, 1);
    chk("async_sclk", 0, if_a.dac_sclk, 0);
    chk("async_busy", 0, if_a.busy, 0);
    repeat (2) step();
    rst = 1'b0;
    repeat (2) step();
    q[0].push_back(8'h3C);
    run_until_idle(200);
    chk("after_reset_word", 0, last_cap[0], 16'h33C0);

`ifdef DAC_SPI_DOUBLE_BUFFER_EN
    // back-to-back frames through the pending register
    q[0].push_back(8'h11); q[0].push_back(8'h22);
    run_until_idle(300);
    chk("db_period", 0, last_period[0], 68);
    chk("db_second_word", 0, last_cap[0], 16'h3220);
`endif

    repeat (5) step();
    for (int d = 0; d < 2; d++) begin
      chk("frames_seen", d, frames_seen[d], frames_started[d]);
      chk("samples_left", d, q[d].size(), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
